// File: rtl/im_loader.sv
// Boot loader: receives a big-endian word count and program bytes, writes instruction memory.
// Optional macro IM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and drives err.
module im_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_f,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        im_we,
    output logic [15:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        core_hold,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        DATA,
        WRITE,
`ifdef IM_LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE
    } state_t;

    state_t      state;
    logic [7:0]  cnt_hi;
    logic [15:0] words_left;
    logic [15:0] word_idx;
    logic [23:0] word_buf;
    logic [1:0]  byte_cnt;
    logic        accept;

`ifdef IM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
    logic        err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign accept = rx_valid && rx_ready;

    always_ff @(posedge clk) begin
        if (rst_f) begin
            state      <= IDLE;
            rx_ready   <= 1'b0;
            im_we      <= 1'b0;
            im_addr    <= 16'h0000;
            im_wdata   <= 32'h0;
            core_hold  <= 1'b0;
            done       <= 1'b0;
            cnt_hi     <= 8'h00;
            words_left <= 16'h0000;
            word_idx   <= 16'h0000;
            word_buf   <= 24'h0;
            byte_cnt   <= 2'd0;
`ifdef IM_LOADER_CHECKSUM_EN
            csum       <= 8'h00;
            err_q      <= 1'b0;
`endif
        end else begin
            im_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= CNT_HI;
                        rx_ready  <= 1'b1;
                        core_hold <= 1'b1;
                        done      <= 1'b0;
                        byte_cnt  <= 2'd0;
`ifdef IM_LOADER_CHECKSUM_EN
                        csum      <= 8'h00;
                        err_q     <= 1'b0;
`endif
                    end
                end
                CNT_HI: begin
                    if (accept) begin
                        cnt_hi <= rx_data;
                        state  <= CNT_LO;
`ifdef IM_LOADER_CHECKSUM_EN
                        csum   <= csum ^ rx_data;
`endif
                    end
                end
                CNT_LO: begin
                    if (accept) begin
                        words_left <= {cnt_hi, rx_data};
                        word_idx   <= 16'h0000;
                        byte_cnt   <= 2'd0;
`ifdef IM_LOADER_CHECKSUM_EN
                        csum       <= csum ^ rx_data;
`endif
                        if ({cnt_hi, rx_data} == 16'h0000) begin
`ifdef IM_LOADER_CHECKSUM_EN
                            state     <= CHK;
`else
                            state     <= DONE;
                            rx_ready  <= 1'b0;
                            core_hold <= 1'b0;
                            done      <= 1'b1;
`endif
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
`ifdef IM_LOADER_CHECKSUM_EN
                        csum <= csum ^ rx_data;
`endif
                        // The fourth byte completes the word; it is issued straight from the input.
                        if (byte_cnt == 2'd3) begin
                            state    <= WRITE;
                            rx_ready <= 1'b0;
                            im_we    <= 1'b1;
                            im_wdata <= {word_buf, rx_data};
                            im_addr  <= BASE_ADDR + word_idx;
                            byte_cnt <= 2'd0;
                        end else begin
                            word_buf <= {word_buf[15:0], rx_data};
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    word_idx   <= word_idx + 16'd1;
                    words_left <= words_left - 16'd1;
                    if (words_left == 16'd1) begin
`ifdef IM_LOADER_CHECKSUM_EN
                        state     <= CHK;
                        rx_ready  <= 1'b1;
`else
                        state     <= DONE;
                        core_hold <= 1'b0;
                        done      <= 1'b1;
`endif
                    end else begin
                        state    <= DATA;
                        rx_ready <= 1'b1;
                    end
                end
`ifdef IM_LOADER_CHECKSUM_EN
                CHK: begin
                    if (accept) begin
                        err_q     <= (rx_data != csum);
                        state     <= DONE;
                        rx_ready  <= 1'b0;
                        core_hold <= 1'b0;
                        done      <= 1'b1;
                    end
                end
`endif
                default: begin
                    state    <= IDLE;
                    rx_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Directed testbench for im_loader; a second instance at BASE_ADDR=FFFF checks address wrap.
module tb_im_loader;

    logic        clk = 1'b0;
    logic        rst_f;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;

    logic        rx_ready, im_we, core_hold, done, err;
    logic [15:0] im_addr;
    logic [31:0] im_wdata;

    logic        wrapRxReady, wrapWe, wrapCoreHold, wrapDone, wrapErr;
    logic [15:0] wrapAddr;
    logic [31:0] wrapWdata;

    im_loader #(.BASE_ADDR(16'h0000)) dut (
        .clk(clk), .rst_f(rst_f), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .core_hold(core_hold), .done(done), .err(err)
    );

    im_loader #(.BASE_ADDR(16'hFFFF)) dutWrap (
        .clk(clk), .rst_f(rst_f), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(wrapRxReady), .im_we(wrapWe), .im_addr(wrapAddr), .im_wdata(wrapWdata),
        .core_hold(wrapCoreHold), .done(wrapDone), .err(wrapErr)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;
    int weReadyOverlap = 0;
    int latency;

    logic [47:0] writeQ[$];
    logic [47:0] wrapQ[$];
    logic [47:0] expQ[$];
    logic [7:0]  streamQ[$];
`ifdef IM_LOADER_CHECKSUM_EN
    bit          badChecksum = 1'b0;
`endif

    // Capture every write strobe and flag any cycle where a byte could be taken during a write.
    always @(negedge clk) begin
        if (im_we) writeQ.push_back({im_addr, im_wdata});
        if (wrapWe) wrapQ.push_back({wrapAddr, wrapWdata});
        if (im_we && rx_ready) weReadyOverlap++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] streamXor();
        logic [7:0] x = 8'h00;
        foreach (streamQ[i]) x = x ^ streamQ[i];
        return x;
    endfunction

    task automatic sendByte(input logic [7:0] b, input int gap, input bit pokeStart);
        int waitCycles = 0;
        bit ready = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            rx_valid = 1'b0;
            start    = pokeStart && (g == 0);
        end
        @(negedge clk);
        start    = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        do begin
            ready = rx_ready;
            @(posedge clk);
            if (!ready) begin
                waitCycles++;
                @(negedge clk);
            end
        end while (!ready && waitCycles < 50);
        if (!ready) checkOutput("rx_ready timeout", 64'd0, 64'd1);
    endtask

    task automatic startPulse();
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        checkOutput("core_hold during load", core_hold, 1);
        checkOutput("done cleared by start", done, 0);
        checkOutput("err cleared by start", err, 0);
    endtask

    task automatic applyStimulus(input int gap, input bit pokeStart);
        startPulse();
        foreach (streamQ[i]) sendByte(streamQ[i], (i == 0) ? 0 : gap, pokeStart && (i == 4));
`ifdef IM_LOADER_CHECKSUM_EN
        sendByte(badChecksum ? 8'h03 : streamXor(), gap, 1'b0);
`endif
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic waitDone(output int cycles);
        cycles = 1;
        while (!done && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("done reached", done, 1);
    endtask

    task automatic checkWrites(input string tag, input bit useWrap);
        logic [47:0] got;
        checkOutput({tag, " count"}, useWrap ? wrapQ.size() : writeQ.size(), expQ.size());
        for (int i = 0; i < expQ.size(); i++) begin
            if (useWrap) got = (i < wrapQ.size()) ? wrapQ[i] : '1;
            else         got = (i < writeQ.size()) ? writeQ[i] : '1;
            checkOutput({tag, " entry"}, got, expQ[i]);
        end
    endtask

    task automatic clearCapture();
        @(negedge clk);
        writeQ.delete();
        wrapQ.delete();
        weReadyOverlap = 0;
    endtask

    initial begin
        rst_f    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("reset rx_ready", rx_ready, 0);
        checkOutput("reset im_we", im_we, 0);
        checkOutput("reset im_addr", im_addr, 16'h0000);
        checkOutput("reset im_wdata", im_wdata, 32'h0);
        checkOutput("reset core_hold", core_hold, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset err", err, 0);
        rst_f = 1'b0;

        // Two-word load, plus the wrapping copy at BASE_ADDR=FFFF.
        clearCapture();
        streamQ = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        applyStimulus(0, 1'b0);
        waitDone(latency);
        expQ = '{48'h0000_11223344, 48'h0001_AABBCCDD};
        checkWrites("two-word", 1'b0);
        expQ = '{48'hFFFF_11223344, 48'h0000_AABBCCDD};
        checkWrites("wrap", 1'b1);
        checkOutput("two-word core_hold", core_hold, 0);
        checkOutput("two-word err", err, 0);
        checkOutput("two-word rx_ready", rx_ready, 0);

        // Empty program.
        clearCapture();
        streamQ = '{8'h00, 8'h00};
        applyStimulus(0, 1'b0);
        waitDone(latency);
        checkOutput("n0 latency", latency <= 2, 1);
        checkOutput("n0 writes", writeQ.size(), 0);
        checkOutput("n0 core_hold", core_hold, 0);

        // Stalled stream with a stray start pulse mid-load.
        clearCapture();
        streamQ = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        applyStimulus(3, 1'b1);
        waitDone(latency);
        expQ = '{48'h0000_11223344, 48'h0001_AABBCCDD};
        checkWrites("stall", 1'b0);
        checkOutput("stall rx_ready in WRITE", weReadyOverlap, 0);

        // Reset after two data bytes, then a fresh one-word load.
        clearCapture();
        startPulse();
        sendByte(8'h00, 0, 1'b0);
        sendByte(8'h02, 0, 1'b0);
        sendByte(8'h11, 0, 1'b0);
        sendByte(8'h22, 0, 1'b0);
        @(negedge clk);
        rx_valid = 1'b0;
        rst_f    = 1'b1;
        @(negedge clk);
        rst_f    = 1'b0;
        checkOutput("midreset core_hold", core_hold, 0);
        checkOutput("midreset rx_ready", rx_ready, 0);
        checkOutput("midreset done", done, 0);
        streamQ = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        applyStimulus(0, 1'b0);
        waitDone(latency);
        expQ = '{48'h0000_DEADBEEF};
        checkWrites("midreset", 1'b0);

`ifdef IM_LOADER_CHECKSUM_EN
        streamQ = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        badChecksum = 1'b0;
        applyStimulus(0, 1'b0);
        waitDone(latency);
        checkOutput("checksum good err", err, 0);
        badChecksum = 1'b1;
        applyStimulus(0, 1'b0);
        waitDone(latency);
        checkOutput("checksum bad err", err, 1);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
